buffered_loopback: RTL

BUFFERED_LOOPBACK -- requirements
Module: buffered_loopback

---
 rtl/buffered_loopback.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/buffered_loopback.sv
// buffered_loopback
// Receives words from a UART receiver, optionally transforms them, buffers
// them in a FIFO and feeds them to a UART transmitter one word at a time.
//
// Parameters
//   WIDTH  data word width in bits (1..32)
//   DEPTH  FIFO entries, power of two, at least 2
//   CW     width of the fill-count output
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   reset_     asynchronous active-low reset
//   rx_data    received word, valid while rx_valid is high
//   rx_valid   single-cycle receive strobe
//   mode       0 pass, 1 invert, 2 increment, 3 discard
//   tx_busy    transmitter busy indication
//   ovf_clear  synchronous clear of the overflow flag
//   tx_data    registered word to the transmitter
//   tx_valid   single-cycle transmit strobe
//   count      FIFO fill level, 0..DEPTH
//   overflow   sticky flag, set when a word is lost to a full FIFO
module buffered_loopback #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    input  logic [1:0]       mode,
    input  logic             tx_busy,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        DRAIN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_txData;
    logic             r_txValid;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [WIDTH-1:0] w_xform;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic             w_ovfSet;

    // Transform the incoming word with the mode sampled in the same cycle.
    always_comb begin
        w_xform = rx_data;
        case (mode)
            2'd1:    w_xform = ~rx_data;
            2'd2:    w_xform = rx_data + WIDTH'(1);
            default: w_xform = rx_data;
        endcase
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // only lost when no pop happens alongside it.
    always_comb begin
        w_push   = rx_valid && (mode != 2'd3);
        w_pop    = (r_state == IDLE) && (r_count != '0) && !tx_busy;
        w_full   = (r_count == FULL_LEVEL);
        w_accept = w_push && (!w_full || w_pop);
        w_ovfSet = w_push && w_full && !w_pop;
    end

    // Storage is intentionally left out of reset; pointers alone define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= w_xform;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new overflow takes priority over a clear in the same cycle.
            if (w_ovfSet) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit handshake: send one word from IDLE, then wait for the
    // transmitter to go busy and come back before sending the next.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= IDLE;
            r_txData  <= '0;
            r_txValid <= 1'b0;
        end else begin
            r_txValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_txData  <= r_mem[r_rdPtr];
                        r_txValid <= 1'b1;
                        r_state   <= ACK;
                    end
                end
                ACK: begin
                    if (tx_busy) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data  = r_txData;
    assign tx_valid = r_txValid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
